// File: rtl/phase_code_scheduler_pkg.sv
// Shared types and constants for the phase-code scheduler.
//   state_e      : frame sequencer states
//   DefNumSize   : default bits per encoded number
//   DefTauW      : default bin width in clk cycles
//   DefTailBins  : default number of LOW bins closing a frame
//   frame_len()  : cycles from ARM rise to IDLE return
package phase_code_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StGap,
    StBits,
    StTail
  } state_e;

  localparam int unsigned DefNumSize  = 7;
  localparam int unsigned DefTauW     = 500;
  localparam int unsigned DefTailBins = 2;

  function automatic int unsigned frame_len(input int unsigned num_size,
                                            input int unsigned tail_bins,
                                            input int unsigned tau_w);
    return (2 + num_size + tail_bins) * tau_w;
  endfunction

  localparam int unsigned DefFrameLen = frame_len(DefNumSize, DefTailBins, DefTauW);

endpackage

// File: rtl/phase_code_scheduler_if.sv
// Channel-side bus of the phase-code scheduler.
//   enable   : grants allowed when 1
//   req      : per-channel update request
//   num_in   : per-channel numbers, channel i at [i*NUM_SIZE +: NUM_SIZE]
//   sig_out  : per-channel serial code lines
//   busy     : frame in progress
//   grant_ch : channel of current/last frame
//   done     : pulse on the final TAIL cycle
// master drives requests and observes lines; slave is the scheduler.
interface phase_code_scheduler_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned NUM_SIZE = 7
) ();

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                         enable;
  logic [NUM_CH-1:0]            req;
  logic [NUM_CH*NUM_SIZE-1:0]   num_in;
  logic [NUM_CH-1:0]            sig_out;
  logic                         busy;
  logic [CH_W-1:0]              grant_ch;
  logic                         done;

  modport master (
    output enable, req, num_in,
    input  sig_out, busy, grant_ch, done
  );

  modport slave (
    input  enable, req, num_in,
    output sig_out, busy, grant_ch, done
  );

endinterface

// File: rtl/phase_code_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   pending : request bits
//   ptr     : channel with highest priority this round
//   valid   : at least one channel pending
//   idx     : first pending channel at or after ptr, wrapping
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   ptr,
  output logic              valid,
  output logic [CH_W-1:0]   idx
);

  function automatic logic [CH_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    return CH_W'((base + off) % NUM_CH);
  endfunction

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!valid && pending[wrap_idx(32'(ptr), i)]) begin
        valid = 1'b1;
        idx   = wrap_idx(32'(ptr), i);
      end
    end
  end

endmodule

// File: rtl/phase_code_scheduler.sv
// Shares one serial-code timing engine among NUM_CH channels. A round-robin arbiter grants
// one pending channel; the engine then drives that channel's line with ARM (HIGH), GAP (LOW),
// NUM_SIZE data bins MSB first and TAIL_BINS LOW bins, each bin TAU_W cycles long.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of phase_code_scheduler_if (enable, req, num_in in; sig_out, busy,
//         grant_ch, done out, all registered)
module phase_code_scheduler
  import phase_code_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_SIZE   = DefNumSize,
  parameter int unsigned TIMER_SIZE = 13,
  parameter int unsigned TAU_W      = DefTauW,
  parameter int unsigned TAIL_BINS  = DefTailBins
) (
  input logic                 clk,
  input logic                 rst,
  phase_code_scheduler_if.slave bus
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BIT_W  = (NUM_SIZE > 1) ? $clog2(NUM_SIZE) : 1;
  localparam int unsigned TAIL_W = (TAIL_BINS > 1) ? $clog2(TAIL_BINS) : 1;

  localparam logic [TIMER_SIZE-1:0] TimerLast   = TIMER_SIZE'(TAU_W - 1);
  localparam logic [TIMER_SIZE-1:0] TimerPenult = TIMER_SIZE'(TAU_W - 2);
  localparam logic [BIT_W-1:0]      BitLast     = BIT_W'(NUM_SIZE - 1);
  localparam logic [TAIL_W-1:0]     TailLast    = TAIL_W'(TAIL_BINS - 1);
  localparam logic [CH_W-1:0]       ChLast      = CH_W'(NUM_CH - 1);

  state_e                state_q, state_d;
  logic [TIMER_SIZE-1:0] timer_q, timer_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [TAIL_W-1:0]     tail_q, tail_d;
  logic [NUM_SIZE-1:0]   shift_q, shift_d;
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [NUM_CH-1:0]     sig_q, sig_d;
  logic [NUM_CH-1:0]     clear_mask;
  logic [CH_W-1:0]       ptr_q, ptr_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  line_d;
  logic                  bin_end;
  logic                  arb_valid;
  logic [CH_W-1:0]       arb_idx;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .pending (pending_q),
    .ptr     (ptr_q),
    .valid   (arb_valid),
    .idx     (arb_idx)
  );

  assign bin_end = (timer_q == TimerLast);

  always_comb begin
    state_d    = state_q;
    timer_d    = bin_end ? '0 : timer_q + 1'b1;
    bit_d      = bit_q;
    tail_d     = tail_q;
    shift_d    = shift_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    line_d     = 1'b0;
    clear_mask = '0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus.enable && arb_valid) begin
          state_d             = StArm;
          grant_d             = arb_idx;
          shift_d             = bus.num_in[32'(arb_idx) * NUM_SIZE +: NUM_SIZE];
          clear_mask[arb_idx] = 1'b1;
          ptr_d               = (arb_idx == ChLast) ? '0 : arb_idx + 1'b1;
          busy_d              = 1'b1;
          line_d              = 1'b1;
        end
      end
      StArm: begin
        line_d = 1'b1;
        if (bin_end) begin
          state_d = StGap;
          line_d  = 1'b0;
        end
      end
      StGap: begin
        if (bin_end) begin
          state_d = StBits;
          bit_d   = '0;
          line_d  = shift_q[NUM_SIZE-1];
        end
      end
      StBits: begin
        // The MSB of shift_q is always the bit on the line.
        line_d = shift_q[NUM_SIZE-1];
        if (bin_end) begin
          if (bit_q == BitLast) begin
            state_d = StTail;
            tail_d  = '0;
            line_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q << 1;
            line_d  = shift_q[NUM_SIZE-2];
          end
        end
      end
      StTail: begin
        // done is registered, so raise it one cycle ahead to land on the last TAIL cycle.
        if (tail_q == TailLast && timer_q == TimerPenult) begin
          done_d = 1'b1;
        end
        if (bin_end) begin
          if (tail_q == TailLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            tail_d = tail_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    sig_d          = '0;
    sig_d[grant_d] = line_d;
    pending_d      = (pending_q & ~clear_mask) | bus.req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_q     <= '0;
      tail_q    <= '0;
      shift_q   <= '0;
      pending_q <= '0;
      sig_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      tail_q    <= tail_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
      sig_q     <= sig_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sig_out  = sig_q;
  assign bus.busy     = busy_q;
  assign bus.grant_ch = grant_q;
  assign bus.done     = done_q;

endmodule
